// File: rtl/imm_extend_stage.sv
// Decode-stage immediate extension register with a 2-entry (output + skid) buffer.
// Optional load-upper support for opcode 4'hF is enabled by defining IMM_EXT_LUI_EN.
module imm_extend_stage #(
  parameter int IMM_W  = 16,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_opcode,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic [4:0]        in_tag,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_opcode,
  output logic [DATA_W-1:0] out_ext,
  output logic              out_sext,
  output logic [4:0]        out_tag
);

  typedef struct packed {
    logic [3:0]        opcode;
    logic [DATA_W-1:0] ext;
    logic              sext;
    logic [4:0]        tag;
  } entry_t;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ONE,
    ST_FULL
  } state_t;

  state_t state_q, state_d;
  entry_t o_q, o_d;
  entry_t s_q, s_d;
  entry_t new_entry;
  logic   out_valid_q, in_ready_q;
  logic   accept, drain;

  function automatic entry_t extend_entry(input logic [3:0]       op,
                                          input logic [IMM_W-1:0] imm,
                                          input logic [4:0]       tag);
    entry_t e;
    e.opcode = op;
    e.tag    = tag;
    e.sext   = (op == 4'h2) || (op == 4'h3) || (op == 4'h7) || (op == 4'h9);
    e.ext    = e.sext ? {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm}
                      : {{(DATA_W-IMM_W){1'b0}}, imm};
`ifdef IMM_EXT_LUI_EN
    // Load-upper places the immediate in the top half; meaningful only when DATA_W == 2*IMM_W.
    if (op == 4'hF) begin
      e.ext  = DATA_W'(imm) << (DATA_W - IMM_W);
      e.sext = 1'b0;
    end
`endif
    return e;
  endfunction

  assign new_entry = extend_entry(in_opcode, in_imm, in_tag);
  assign accept    = in_valid & in_ready_q;
  assign drain     = out_valid_q & out_ready;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    o_d     = o_q;
    s_d     = s_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          o_d     = new_entry;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && drain) begin
          o_d = new_entry;
        end else if (accept) begin
          s_d     = new_entry;
          state_d = ST_FULL;
        end else if (drain) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (drain) begin
          o_d     = s_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // A flush drops both entries; a same-cycle drain has already been seen by the consumer.
    if (flush) begin
      state_d = ST_EMPTY;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      o_q         <= '0;
      s_q         <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      o_q         <= o_d;
      s_q         <= s_d;
      out_valid_q <= (state_d != ST_EMPTY);
      in_ready_q  <= (state_d != ST_FULL);
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_opcode = o_q.opcode;
  assign out_ext    = o_q.ext;
  assign out_sext   = o_q.sext;
  assign out_tag    = o_q.tag;

endmodule

// File: tb/tb_imm_extend_stage.sv
// Directed self-checking bench for imm_extend_stage: extension rules, flow control,
// flush and reset behaviour. Define IMM_EXT_LUI_EN to check the load-upper build.
module tb_imm_extend_stage;

  localparam int IMM_W  = 16;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_opcode;
  logic [IMM_W-1:0]  in_imm;
  logic [4:0]        in_tag;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [3:0]        out_opcode;
  logic [DATA_W-1:0] out_ext;
  logic              out_sext;
  logic [4:0]        out_tag;

  int n_checks = 0;
  int n_fail   = 0;

  imm_extend_stage #(.IMM_W(IMM_W), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_opcode  (in_opcode),
    .in_imm     (in_imm),
    .in_tag     (in_tag),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_opcode (out_opcode),
    .out_ext    (out_ext),
    .out_sext   (out_sext),
    .out_tag    (out_tag)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Inputs are driven and outputs sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [15:0] imm,
                       input logic [4:0] tag);
    in_valid  = v;
    in_opcode = op;
    in_imm    = imm;
    in_tag    = tag;
  endtask

  task automatic fill_full(input logic [4:0] t0, input logic [4:0] t1);
    out_ready = 1'b0;
    drive(1'b1, 4'h1, 16'h0011, t0);
    step();
    drive(1'b1, 4'h1, 16'h0022, t1);
    step();
    drive(1'b0, 4'h0, 16'h0000, 5'd0);
  endtask

  logic [31:0] exp_ext;

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 4'h0, 16'h0000, 5'd0);
    step();
    step();
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_ext", out_ext, 32'd0);
    check("reset_out_opcode", 32'(out_opcode), 32'd0);
    check("reset_out_sext_tag", {26'd0, out_sext, out_tag}, 32'd0);
    reset = 1'b0;

    // Sign vs zero extension of a negative immediate, back to back, one-cycle latency.
    out_ready = 1'b1;
    drive(1'b1, 4'h2, 16'h8000, 5'd5);
    step();
    check("op2_valid", 32'(out_valid), 32'd1);
    check("op2_ext", out_ext, 32'hFFFF8000);
    check("op2_sext", 32'(out_sext), 32'd1);
    check("op2_tag", 32'(out_tag), 32'd5);
    drive(1'b1, 4'h4, 16'h8000, 5'd6);
    step();
    check("op4_ext", out_ext, 32'h00008000);
    check("op4_sext", 32'(out_sext), 32'd0);
    check("op4_opcode", 32'(out_opcode), 32'h4);
    drive(1'b0, 4'h0, 16'h0000, 5'd0);
    step();
    check("drain_empty", 32'(out_valid), 32'd0);

    // Opcode sweep at full throughput.
    for (int op = 0; op < 16; op++) begin
      drive(1'b1, 4'(op), 16'hFFFF, 5'(op));
      step();
      if (op == 2 || op == 3 || op == 7 || op == 9) exp_ext = 32'hFFFFFFFF;
      else exp_ext = 32'h0000FFFF;
`ifdef IMM_EXT_LUI_EN
      if (op == 15) exp_ext = 32'hFFFF0000;
`endif
      check($sformatf("sweep_ext_op%0d", op), out_ext, exp_ext);
      check($sformatf("sweep_tag_op%0d", op), {26'd0, out_valid, out_tag}, {26'd0, 1'b1, 5'(op)});
    end
    drive(1'b0, 4'h0, 16'h0000, 5'd0);
    step();

    // Backpressure: tags 1,2,3 with the consumer stalled.
    out_ready = 1'b0;
    drive(1'b1, 4'h1, 16'h0001, 5'd1);
    step();
    check("bp_ready_after_1", 32'(in_ready), 32'd1);
    drive(1'b1, 4'h1, 16'h0002, 5'd2);
    step();
    check("bp_ready_after_2", 32'(in_ready), 32'd0);
    check("bp_head_1", 32'(out_tag), 32'd1);
    drive(1'b1, 4'h1, 16'h0003, 5'd3);
    step();
    check("bp_hold_tag", 32'(out_tag), 32'd1);
    check("bp_hold_ext", out_ext, 32'h00000001);
    check("bp_hold_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    step();
    check("bp_out_2", 32'(out_tag), 32'd2);
    check("bp_ready_reopen", 32'(in_ready), 32'd1);
    step();
    check("bp_out_3", {26'd0, out_valid, out_tag}, {26'd0, 1'b1, 5'd3});
    check("bp_out_3_ext", out_ext, 32'h00000003);
    drive(1'b0, 4'h0, 16'h0000, 5'd0);
    step();
    check("bp_no_dup", 32'(out_valid), 32'd0);

    // Flush while full with a same-cycle input.
    fill_full(5'd10, 5'd11);
    check("flush_pre_full", 32'(in_ready), 32'd0);
    flush = 1'b1;
    drive(1'b1, 4'h2, 16'h4444, 5'd12);
    step();
    flush = 1'b0;
    drive(1'b0, 4'h0, 16'h0000, 5'd0);
    check("flush_full_valid", 32'(out_valid), 32'd0);
    check("flush_full_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    step();
    check("flush_full_stays_empty", 32'(out_valid), 32'd0);

    // Flush with one entry held while an input is accepted: the input is discarded.
    out_ready = 1'b0;
    drive(1'b1, 4'h1, 16'h0013, 5'd13);
    step();
    flush = 1'b1;
    drive(1'b1, 4'h1, 16'h0014, 5'd14);
    step();
    flush = 1'b0;
    drive(1'b0, 4'h0, 16'h0000, 5'd0);
    check("flush_one_valid", 32'(out_valid), 32'd0);
    step();
    check("flush_one_no_emit", 32'(out_valid), 32'd0);

    // Reset while full, then a fresh push.
    fill_full(5'd20, 5'd21);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_full_valid", 32'(out_valid), 32'd0);
    check("rst_full_ready", 32'(in_ready), 32'd1);
    check("rst_full_ext", out_ext, 32'd0);
    check("rst_full_misc", {22'd0, out_opcode, out_sext, out_tag}, 32'd0);
    out_ready = 1'b1;
    drive(1'b1, 4'h9, 16'h0001, 5'd7);
    step();
    check("post_rst_ext", out_ext, 32'h00000001);
    check("post_rst_sext_tag", {26'd0, out_sext, out_tag}, {26'd0, 1'b1, 5'd7});

    // Opcode 4'hF: load-upper only in the LUI build.
    drive(1'b1, 4'hF, 16'h1234, 5'd8);
    step();
`ifdef IMM_EXT_LUI_EN
    check("opF_ext", out_ext, 32'h12340000);
`else
    check("opF_ext", out_ext, 32'h00001234);
`endif
    check("opF_sext", 32'(out_sext), 32'd0);
    drive(1'b0, 4'h0, 16'h0000, 5'd0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imm_extend_stage.md
# imm_extend_stage

Decode-stage immediate extension pipeline register for the 32-bit MIPS-style datapath. Accepts a 4-bit opcode, 16-bit immediate and destination tag from instruction decode. Applies sign or zero extension per the opcode class, then presents the 32-bit operand to the ALU-operand mux through a registered valid/ready interface with a 2-entry skid buffer. This is the consumer of the per-opcode extend decision: it both generates that decision and acts on it, with flow control.

## Interface
- IMM_W, 16, immediate width from the instruction word
- DATA_W, 32, extended operand width; must satisfy DATA_W > IMM_W
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  stage can accept; registered, equals "skid entry empty"
- in_opcode  in  4  instruction opcode
- in_imm  in  IMM_W  raw immediate
- in_tag  in  5  destination register index, passed through
- flush  in  1  discard all held entries (branch/redirect)
- out_valid  out  1  output entry valid
- out_ready  in  1  ALU stage accepts
- out_opcode  out  4  opcode of output entry
- out_ext  out  DATA_W  extended immediate
- out_sext  out  1  1 = entry was sign-extended
- out_tag  out  5  destination tag of output entry

## Operation
- Sign-extend opcode set: 4'h2, 4'h3, 4'h7, 4'h9. All other opcodes zero-extend.
- Sign extension: out_ext = {(DATA_W-IMM_W){imm[IMM_W-1]}, imm}. Zero extension: upper bits 0.
- Extension is computed on the input side and stored extended. out_* are direct register outputs with no combinational path from in_*.
- Storage: output register O and skid register S. States:
  - EMPTY: O and S invalid.
  - ONE: O valid, S invalid.
  - FULL: both valid.
- Accept = in_valid & in_ready. Drain = out_valid & out_ready.
- EMPTY: accept -> ONE, entry loads O.
- ONE:
  - accept & drain -> ONE, O reloads.
  - accept only -> FULL, entry loads S.
  - drain only -> EMPTY.
- FULL: in_ready = 0.
  - drain -> ONE, S moves to O.
  - otherwise hold.
- Ordering is strict FIFO: O is always older than S.
- flush: next state EMPTY. Any same-cycle accept is discarded and any same-cycle drain still counts at the consumer. in_ready = 1 the following cycle.
- Reset values: out_valid 0, in_ready 1, out_opcode 0, out_ext 0, out_sext 0, out_tag 0, state EMPTY.

## Timing
- Latency 1 cycle: an entry accepted at edge N is visible on out_* after edge N, when the stage was empty or draining.
- Throughput: 1 entry/cycle sustained while out_ready = 1.
- in_ready is a register. It drops the cycle after S fills and rises the cycle after S drains.
- Simultaneous reset and flush: reset wins, with identical result.
- Reset mid-transfer: entries in O/S are lost and out_valid = 0 after the edge.
- out_* hold stable while out_valid & !out_ready.

## Configuration
- IMM_EXT_LUI_EN defined:
  - Opcode 4'hF is load-upper: out_ext = {imm, (DATA_W-IMM_W){1'b0}}, out_sext = 0.
  - Only valid when DATA_W = 2*IMM_W.
- IMM_EXT_LUI_EN undefined: 4'hF zero-extends like any other non-sign opcode.

## Test plan
- Opcode 4'h2 with imm 16'h8000 -> out_ext 32'hFFFF8000, out_sext 1. Opcode 4'h4 with imm 16'h8000 -> 32'h00008000, out_sext 0. One-cycle latency each.
- Sweep all 16 opcodes with imm 16'hFFFF -> out_ext 32'hFFFFFFFF only for 2, 3, 7, 9; otherwise 32'h0000FFFF.
- Backpressure: out_ready = 0, push tags 1, 2, 3 back to back:
  - tag 3 stalls because in_ready = 0 after the second edge.
  - Raise out_ready: outputs appear in order 1, 2, 3 with no loss or duplication.
- Flush while FULL, with in_valid = 1 in the same cycle -> out_valid = 0 next cycle, in_ready = 1, and the flushed-cycle input is never emitted.
- Reset asserted while FULL -> all out_* zero, in_ready = 1 after the edge. A subsequent push of opcode 4'h9 with imm 16'h0001 -> 32'h00000001.
- IMM_EXT_LUI_EN build: opcode 4'hF with imm 16'h1234 -> 32'h12340000. Without the macro -> 32'h00001234.
